// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter for the MIPS pipeline.
// Holds the fetch PC and advances it by INC whenever fetch can advance. Redirect
// sources, highest priority first: exception entry, ERET return, branch target.
// A branch that resolves while fetch is blocked is held and applied on the first
// edge where fetch can advance again.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   stall        hazard-unit hold; blocks sequential advance and branch redirect
//   fetch_ready  instruction memory accepts the current pc this cycle
//   exc_req      exception taken; redirects to EXC_VEC even while stalled
//   eret_req     ERET retiring; redirects to epc even while stalled
//   epc          ERET return address
//   br_req       branch/jump resolved taken
//   br_target    branch/jump target address
//   pc           current fetch PC (registered)
//   pc_adel      fetch address misaligned (combinational from pc)
//   br_pending   a branch target is held awaiting advance (registered)
//   redirect     one-cycle pulse: pc was loaded by a redirect on the last edge
module pc_gen #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC = 32'hbfc00000,
    parameter logic [WIDTH-1:0]  EXC_VEC   = 32'hbfc00380,
    parameter int unsigned       INC       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_req,
    input  logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] pc,
    output logic             pc_adel,
    output logic             br_pending,
    output logic             redirect
);

    logic [WIDTH-1:0] pc_q,         pc_d;
    logic [WIDTH-1:0] br_hold_q,    br_hold_d;
    logic             br_pending_q, br_pending_d;
    logic             redirect_q,   redirect_d;
    logic             advance_c;

    assign advance_c = !stall && fetch_ready;

    // Next-state selection in redirect priority order.
    always_comb begin
        pc_d         = pc_q;
        br_hold_d    = br_hold_q;
        br_pending_d = br_pending_q;
        redirect_d   = 1'b0;

        if (exc_req) begin
            // Exception wins over ERET and any branch, stalled or not.
            pc_d         = EXC_VEC;
            br_pending_d = 1'b0;
            redirect_d   = 1'b1;
        end else if (eret_req) begin
            pc_d         = epc;
            br_pending_d = 1'b0;
            redirect_d   = 1'b1;
        end else if (advance_c && (br_req || br_pending_q)) begin
            // A fresh branch is newer than any held target.
            pc_d         = br_req ? br_target : br_hold_q;
            br_pending_d = 1'b0;
            redirect_d   = 1'b1;
        end else if (advance_c) begin
            // Sequential fetch wraps modulo 2^WIDTH.
            pc_d = pc_q + WIDTH'(INC);
        end else if (br_req) begin
            // Fetch blocked: hold the newest branch target until advance.
            br_pending_d = 1'b1;
            br_hold_d    = br_target;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_VEC;
            br_hold_q    <= '0;
            br_pending_q <= 1'b0;
            redirect_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            br_hold_q    <= br_hold_d;
            br_pending_q <= br_pending_d;
            redirect_q   <= redirect_d;
        end
    end

    assign pc         = pc_q;
    assign pc_adel    = |pc_q[1:0];
    assign br_pending = br_pending_q;
    assign redirect   = redirect_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed checks of pc_gen at the default 32-bit configuration and
// an 8-bit instance used for wrap-around and asynchronous reset.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        fetch_ready;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        br_req;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        pc_adel;
    logic        br_pending;
    logic        redirect;

    logic        rst8;
    logic        fr8;
    logic [7:0]  pc8;
    logic        pc_adel8;
    logic        br_pending8;
    logic        redirect8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_gen u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .exc_req     (exc_req),
        .eret_req    (eret_req),
        .epc         (epc),
        .br_req      (br_req),
        .br_target   (br_target),
        .pc          (pc),
        .pc_adel     (pc_adel),
        .br_pending  (br_pending),
        .redirect    (redirect)
    );

    pc_gen #(
        .WIDTH     (8),
        .RESET_VEC (8'hfc),
        .EXC_VEC   (8'h80),
        .INC       (4)
    ) u_dut8 (
        .clk         (clk),
        .rst         (rst8),
        .stall       (1'b0),
        .fetch_ready (fr8),
        .exc_req     (1'b0),
        .eret_req    (1'b0),
        .epc         (8'h00),
        .br_req      (1'b0),
        .br_target   (8'h00),
        .pc          (pc8),
        .pc_adel     (pc_adel8),
        .br_pending  (br_pending8),
        .redirect    (redirect8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc,
                             input logic e_pend, input logic e_redir);
        chk({tag, ".pc"},       pc,                 e_pc);
        chk({tag, ".pending"},  32'(br_pending),    32'(e_pend));
        chk({tag, ".redirect"}, 32'(redirect),      32'(e_redir));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; fetch_ready = 1'b1;
        exc_req = 1'b0; eret_req = 1'b0; epc = '0;
        br_req = 1'b0; br_target = '0;
        rst8 = 1'b1; fr8 = 1'b1;

        // Reset state held across edges.
        #2;
        chk_state("reset_async", 32'hbfc00000, 1'b0, 1'b0);
        tick();
        tick();
        chk_state("reset_hold", 32'hbfc00000, 1'b0, 1'b0);
        chk("reset8.pc", 32'(pc8), 32'h000000fc);
        rst  = 1'b0;
        rst8 = 1'b0;

        // Sequential fetch from the reset vector; 8-bit instance wraps fc -> 00.
        tick();
        chk_state("seq1", 32'hbfc00004, 1'b0, 1'b0);
        chk("seq1.adel", 32'(pc_adel), 32'd0);
        chk("wrap8.pc", 32'(pc8), 32'h00000000);
        chk("wrap8.redirect", 32'(redirect8), 32'd0);
        fr8 = 1'b0;
        tick();
        chk_state("seq2", 32'hbfc00008, 1'b0, 1'b0);
        tick();
        chk_state("seq3", 32'hbfc0000c, 1'b0, 1'b0);
        chk("hold8.pc", 32'(pc8), 32'h00000000);

        // Async reset on the 8-bit instance between edges.
        rst8 = 1'b1;
        #2;
        chk("async8.pc", 32'(pc8), 32'h000000fc);
        rst8 = 1'b0;

        // Branch captured while stalled, applied once stall drops.
        stall = 1'b1; br_req = 1'b1; br_target = 32'h80001000;
        tick();
        chk_state("brstall1", 32'hbfc0000c, 1'b1, 1'b0);
        br_req = 1'b0;
        tick();
        chk_state("brstall2", 32'hbfc0000c, 1'b1, 1'b0);
        stall = 1'b0;
        tick();
        chk_state("brapply", 32'h80001000, 1'b0, 1'b1);
        tick();
        chk_state("brnext", 32'h80001004, 1'b0, 1'b0);

        // Exception during stall discards the pending branch.
        stall = 1'b1; br_req = 1'b1; br_target = 32'h80001000;
        tick();
        chk_state("excpend", 32'h80001004, 1'b1, 1'b0);
        br_req = 1'b0; exc_req = 1'b1;
        tick();
        chk_state("exc", 32'hbfc00380, 1'b0, 1'b1);
        exc_req = 1'b0;
        tick();
        chk_state("exchold", 32'hbfc00380, 1'b0, 1'b0);

        // Exception beats ERET beats branch in the same cycle.
        stall = 1'b0;
        exc_req = 1'b1; eret_req = 1'b1; epc = 32'h80000040;
        br_req = 1'b1; br_target = 32'h80001000;
        tick();
        chk_state("simul", 32'hbfc00380, 1'b0, 1'b1);
        exc_req = 1'b0; br_req = 1'b0;
        tick();
        chk_state("eret", 32'h80000040, 1'b0, 1'b1);
        eret_req = 1'b0;

        // Misaligned branch target then memory backpressure.
        br_req = 1'b1; br_target = 32'h80000102;
        tick();
        chk_state("mis", 32'h80000102, 1'b0, 1'b1);
        chk("mis.adel", 32'(pc_adel), 32'd1);
        br_req = 1'b0; fetch_ready = 1'b0;
        tick();
        chk_state("bp1", 32'h80000102, 1'b0, 1'b0);
        tick();
        chk_state("bp2", 32'h80000102, 1'b0, 1'b0);
        fetch_ready = 1'b1;
        tick();
        chk_state("bpadv", 32'h80000106, 1'b0, 1'b0);
        chk("bpadv.adel", 32'(pc_adel), 32'd1);

        // Newest held branch wins.
        stall = 1'b1; br_req = 1'b1; br_target = 32'h80002000;
        tick();
        br_target = 32'h80003000;
        tick();
        chk_state("newest.held", 32'h80000106, 1'b1, 1'b0);
        stall = 1'b0; br_req = 1'b0;
        tick();
        chk_state("newest", 32'h80003000, 1'b0, 1'b1);

        // Reset mid-stall with a pending branch loses the branch.
        stall = 1'b1; br_req = 1'b1; br_target = 32'h80004000;
        tick();
        chk_state("rstpend", 32'h80003000, 1'b1, 1'b0);
        br_req = 1'b0;
        rst = 1'b1;
        #2;
        chk_state("rstmid", 32'hbfc00000, 1'b0, 1'b0);
        rst = 1'b0; stall = 1'b0;
        tick();
        chk_state("rstafter", 32'hbfc00004, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
